instr_encoder: RTL and testbench

- Inverse of the immediate-extraction path: packs an instruction class, register fields and a 64-bit signed immediate into a 32-bit LEGv8 instruction word.
- Covers LDUR and STUR (D-format) and CBZ (CB-format).
- 2-stage pipeline with valid/ready handshakes on both sides.
- Used by the test infrastructure and the instruction-memory loader to build program images. Also drives round-trip checks against signext: `signext(out_instr)` must equal `in_imm` for every accepted, error-free word.

---
 rtl/legv8_enc_pkg.sv | 18 +
 rtl/imm_range_check.sv | 18 +
 rtl/instr_encoder.sv | 117 +++++++++++
 tb/tb_instr_encoder.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_enc_pkg.sv
// rtl/legv8_enc_pkg.sv - LEGv8 encoder instruction classes, opcodes and field widths
package legv8_enc_pkg;

  typedef enum logic [1:0] {
    K_LDUR = 2'd0,
    K_STUR = 2'd1,
    K_CBZ  = 2'd2,
    K_RSVD = 2'd3
  } kind_e;

  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;

  localparam int DT_W = 9;
  localparam int CB_W = 19;

endpackage

// File: rtl/imm_range_check.sv
// rtl/imm_range_check.sv - signed-range test of a 64-bit immediate against the D or CB field
module imm_range_check
  import legv8_enc_pkg::*;
(
  input  logic [63:0] imm_i,
  input  logic        cb_sel_i,
  output logic        legal_o
);

  logic dt_ok;
  logic cb_ok;

  // Legal when every bit above the field's sign bit replicates that sign bit.
  assign dt_ok   = (imm_i[63:DT_W-1] == {(64-DT_W+1){imm_i[DT_W-1]}});
  assign cb_ok   = (imm_i[63:CB_W-1] == {(64-CB_W+1){imm_i[CB_W-1]}});
  assign legal_o = cb_sel_i ? cb_ok : dt_ok;

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - two-stage LDUR/STUR/CBZ instruction packer with valid/ready on both sides
module instr_encoder
  import legv8_enc_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_kind,
  input  logic [63:0]          in_imm,
  input  logic [4:0]           in_rn,
  input  logic [4:0]           in_rt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic            s1_valid_q;
  kind_e           s1_kind_q;
  logic [CB_W-1:0] s1_imm_q;
  logic [4:0]      s1_rn_q;
  logic [4:0]      s1_rt_q;
  logic            s1_err_q;
  logic            s1_err_d;

  logic                 s2_valid_q;
  logic [31:0]          instr_q;
  logic [31:0]          instr_d;
  logic                 err_q;
  logic                 err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic  s2_load;
  logic  s1_load;
  logic  imm_legal;
  logic  err_inc;
  kind_e in_kind_e;

  assign in_kind_e = kind_e'(in_kind);
  assign s2_load   = !s2_valid_q || out_ready;
  assign s1_load   = !s1_valid_q || s2_load;
  assign in_ready  = s1_load;

  imm_range_check u_range (
    .imm_i    (in_imm),
    .cb_sel_i (in_kind_e == K_CBZ),
    .legal_o  (imm_legal)
  );

  assign s1_err_d = (in_kind_e == K_RSVD) || !imm_legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_kind_q  <= K_LDUR;
      s1_imm_q   <= '0;
      s1_rn_q    <= '0;
      s1_rt_q    <= '0;
      s1_err_q   <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_kind_q <= in_kind_e;
        s1_imm_q  <= in_imm[CB_W-1:0];
        s1_rn_q   <= in_rn;
        s1_rt_q   <= in_rt;
        s1_err_q  <= s1_err_d;
      end
    end
  end

  always_comb begin
    instr_d = 32'h0000_0000;
    err_d   = s1_err_q;
    if (!s1_err_q) begin
      case (s1_kind_q)
        K_LDUR:  instr_d = {OP_LDUR, s1_imm_q[DT_W-1:0], 2'b00, s1_rn_q, s1_rt_q};
        K_STUR:  instr_d = {OP_STUR, s1_imm_q[DT_W-1:0], 2'b00, s1_rn_q, s1_rt_q};
        K_CBZ:   instr_d = {OP_CBZ, s1_imm_q, s1_rt_q};
        default: err_d   = 1'b1;
      endcase
    end
  end

  // Rejected words are counted when they leave, so a stalled error counts once.
  assign err_inc = s2_valid_q && out_ready && err_q && (err_cnt_q != '1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      instr_q    <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          instr_q <= instr_d;
          err_q   <= err_d;
        end
      end
      if (err_inc) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

  typedef struct {
    logic [1:0]  kind;
    logic [63:0] imm;
    logic [4:0]  rn;
    logic [4:0]  rt;
  } req_t;

  typedef struct {
    logic        err;
    logic [31:0] instr;
  } rsp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [63:0] in_imm;
  logic [4:0]  in_rn;
  logic [4:0]  in_rt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_count;

  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [31:0] sat_out_instr;
  logic        sat_out_err;
  logic [1:0]  sat_err_count;

  int tests;
  int fails;

  req_t req_q[$];
  rsp_t got_q[$];

  instr_encoder #(.ERR_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_imm(in_imm), .in_rn(in_rn), .in_rt(in_rt),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_count(err_count)
  );

  instr_encoder #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_kind(in_kind), .in_imm(in_imm), .in_rn(in_rn), .in_rt(in_rt),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_instr(sat_out_instr),
    .out_err(sat_out_err), .err_count(sat_err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] signext(input logic [31:0] w);
    if (w[31:21] == 11'h7C2 || w[31:21] == 11'h7C0) return {{55{w[20]}}, w[20:12]};
    else if (w[31:24] == 8'hB4) return {{45{w[23]}}, w[23:5]};
    else return 64'h0;
  endfunction

  function automatic req_t mk(input logic [1:0] k, input longint imm, input logic [4:0] rn,
                              input logic [4:0] rt);
    req_t r;
    r.kind = k;
    r.imm  = imm;
    r.rn   = rn;
    r.rt   = rt;
    return r;
  endfunction

  task automatic load_front();
    if (req_q.size() != 0) begin
      in_valid = 1'b1;
      in_kind  = req_q[0].kind;
      in_imm   = req_q[0].imm;
      in_rn    = req_q[0].rn;
      in_rt    = req_q[0].rt;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic tick();
    logic acc;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) got_q.push_back('{err: out_err, instr: out_instr});
    @(posedge clk);
    @(negedge clk);
    if (acc) void'(req_q.pop_front());
    load_front();
  endtask

  task automatic drain(input int n);
    int budget;
    budget = 0;
    while (got_q.size() < n && budget < 200) begin
      tick();
      budget++;
    end
    tests++;
    if (got_q.size() != n) begin
      fails++;
      $display("FAIL drain_timeout: got %0d words, required %0d", got_q.size(), n);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req_q.delete();
    load_front();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    got_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0 || err_count !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: valid=%b instr=%h err=%b cnt=%0d, required 0/0/0/0",
               out_valid, out_instr, out_err, err_count);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    got_q.delete();
    out_ready = 1'b1;
    req_q.push_back(mk(2'd0, -86, 5'd2, 5'd10));
    load_front();
    tick();
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_latency_early: out_valid=%b, required 0", out_valid);
    end
    tick();
    #1;
    tests++;
    if (out_valid !== 1'b1 || out_instr !== 32'hF85AA04A || out_err !== 1'b0) begin
      fails++;
      $display("FAIL basic_encode: valid=%b instr=%h err=%b, required 1/F85AA04A/0",
               out_valid, out_instr, out_err);
    end
    tests++;
    if (signext(out_instr) !== 64'hFFFF_FFFF_FFFF_FFAA) begin
      fails++;
      $display("FAIL basic_signext: got %h, required FFFFFFFFFFFFFFAA", signext(out_instr));
    end
    drain(1);
  endtask

  task automatic test_range();
    rsp_t exp_q[$];
    got_q.delete();
    out_ready = 1'b1;
    req_q.push_back(mk(2'd1, 255, 5'd3, 5'd4));
    req_q.push_back(mk(2'd1, 256, 5'd3, 5'd4));
    exp_q.push_back('{err: 1'b0, instr: 32'hF80FF064});
    exp_q.push_back('{err: 1'b1, instr: 32'h0});
    load_front();
    drain(2);
    tests++;
    if (err_count !== 16'd1) begin
      fails++;
      $display("FAIL range_err_count1: got %0d, required 1", err_count);
    end
    req_q.push_back(mk(2'd2, -262144, 5'd0, 5'd7));
    req_q.push_back(mk(2'd1, -257, 5'd1, 5'd1));
    req_q.push_back(mk(2'd0, -256, 5'd1, 5'd0));
    req_q.push_back(mk(2'd2, 262143, 5'd0, 5'd31));
    req_q.push_back(mk(2'd2, 262144, 5'd0, 5'd31));
    exp_q.push_back('{err: 1'b0, instr: 32'hB4800007});
    exp_q.push_back('{err: 1'b1, instr: 32'h0});
    exp_q.push_back('{err: 1'b0, instr: 32'hF8500020});
    exp_q.push_back('{err: 1'b0, instr: 32'hB47FFFFF});
    exp_q.push_back('{err: 1'b1, instr: 32'h0});
    load_front();
    drain(7);
    for (int i = 0; i < 7 && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i].err !== exp_q[i].err || got_q[i].instr !== exp_q[i].instr) begin
        fails++;
        $display("FAIL range_word%0d: err=%b instr=%h, required err=%b instr=%h",
                 i, got_q[i].err, got_q[i].instr, exp_q[i].err, exp_q[i].instr);
      end
    end
    tests++;
    if (err_count !== 16'd3) begin
      fails++;
      $display("FAIL range_err_count3: got %0d, required 3", err_count);
    end
  endtask

  task automatic test_reserved_saturation();
    apply_reset();
    for (int i = 0; i < 5; i++) req_q.push_back(mk(2'd3, i, 5'd1, 5'd2));
    load_front();
    drain(5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i].err !== 1'b1 || got_q[i].instr !== 32'h0) begin
        fails++;
        $display("FAIL rsvd_word%0d: err=%b instr=%h, required err=1 instr=0",
                 i, got_q[i].err, got_q[i].instr);
      end
    end
    tests++;
    if (err_count !== 16'd5 || sat_err_count !== 2'd3) begin
      fails++;
      $display("FAIL rsvd_err_count: wide=%0d narrow=%0d, required 5 and 3",
               err_count, sat_err_count);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w[4];
    exp_w[0] = 32'hB4000021;
    exp_w[1] = 32'hB4FFFFE2;
    exp_w[2] = 32'hB4000C83;
    exp_w[3] = 32'hB4FD8F04;
    got_q.delete();
    out_ready = 1'b0;
    req_q.push_back(mk(2'd2, 1, 5'd0, 5'd1));
    req_q.push_back(mk(2'd2, -1, 5'd0, 5'd2));
    req_q.push_back(mk(2'd2, 100, 5'd0, 5'd3));
    req_q.push_back(mk(2'd2, -5000, 5'd0, 5'd4));
    load_front();
    tick();
    tick();
    #1;
    tests++;
    if (in_ready !== 1'b0 || req_q.size() != 2) begin
      fails++;
      $display("FAIL bp_in_ready: in_ready=%b pending=%0d, required 0 and 2", in_ready, req_q.size());
    end
    tests++;
    if (out_valid !== 1'b1 || out_instr !== exp_w[0]) begin
      fails++;
      $display("FAIL bp_hold1: valid=%b instr=%h, required 1/%h", out_valid, out_instr, exp_w[0]);
    end
    tick();
    #1;
    tests++;
    if (out_valid !== 1'b1 || out_instr !== exp_w[0] || out_err !== 1'b0) begin
      fails++;
      $display("FAIL bp_hold2: valid=%b instr=%h err=%b, required 1/%h/0",
               out_valid, out_instr, out_err, exp_w[0]);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_full_release: in_ready=%b, required 1", in_ready);
    end
    drain(4);
    repeat (3) tick();
    tests++;
    if (got_q.size() != 4) begin
      fails++;
      $display("FAIL bp_count: got %0d words, required 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i].instr !== exp_w[i] || got_q[i].err !== 1'b0) begin
        fails++;
        $display("FAIL bp_word%0d: instr=%h err=%b, required %h/0", i, got_q[i].instr,
                 got_q[i].err, exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete();
    out_ready = 1'b0;
    req_q.push_back(mk(2'd3, 0, 5'd0, 5'd0));
    req_q.push_back(mk(2'd0, 1, 5'd0, 5'd0));
    load_front();
    tick();
    tick();
    #1;
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_full: valid=%b in_ready=%b, required 1 and 0", out_valid, in_ready);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || err_count !== 16'h0 || out_instr !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset: valid=%b cnt=%0d instr=%h, required 0/0/0",
               out_valid, err_count, out_instr);
    end
    req_q.delete();
    load_front();
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    got_q.delete();
    req_q.push_back(mk(2'd0, 7, 5'd5, 5'd6));
    load_front();
    tick();
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_after_early: out_valid=%b, required 0", out_valid);
    end
    tick();
    #1;
    tests++;
    if (out_valid !== 1'b1 || out_instr !== 32'hF84070A6) begin
      fails++;
      $display("FAIL mid_after_word: valid=%b instr=%h, required 1/F84070A6", out_valid, out_instr);
    end
    repeat (3) tick();
    tests++;
    if (got_q.size() != 1) begin
      fails++;
      $display("FAIL mid_after_count: got %0d words, required 1", got_q.size());
    end
  endtask

  task automatic test_round_trip();
    logic [63:0] exp_imm[$];
    int          budget;
    longint      v;
    logic [1:0]  k;
    got_q.delete();
    for (int i = 0; i < 1000; i++) begin
      k = 2'($urandom_range(0, 2));
      if (k == 2'd2) v = longint'($urandom_range(0, 524287)) - 262144;
      else v = longint'($urandom_range(0, 511)) - 256;
      req_q.push_back(mk(k, v, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))));
      exp_imm.push_back(v);
    end
    load_front();
    budget = 0;
    while (got_q.size() < 1000 && budget < 5000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      budget++;
    end
    tests++;
    if (got_q.size() != 1000) begin
      fails++;
      $display("FAIL rt_timeout: got %0d words, required 1000", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      tests++;
      if (got_q[i].err !== 1'b0 || signext(got_q[i].instr) !== exp_imm[i]) begin
        fails++;
        $display("FAIL rt_word%0d: err=%b ext=%h, required err=0 ext=%h", i, got_q[i].err,
                 signext(got_q[i].instr), exp_imm[i]);
      end
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_kind   = 2'd0;
    in_imm    = 64'h0;
    in_rn     = 5'd0;
    in_rt     = 5'd0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_range();
    test_reserved_saturation();
    test_backpressure();
    test_reset_mid();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
